// File: rtl/multi_dataflow_mul_mdc_package.sv
// Shared types and constants for the multi-dataflow engine controller:
// FSM state enum, default counter width and the engine status bundle.
package multi_dataflow_mul_mdc_package;

    localparam int unsigned ENGINE_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STARTING,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } engine_state_mul_mdc_t;

    typedef struct packed {
        logic                    busy;
        logic                    done;
        logic [ENGINE_CNT_W-1:0] cnt;
    } flags_engine_multi_dataflow_mul_mdc_t;

endpackage

// File: rtl/multi_dataflow_mul_mdc_engine_cnt.sv
// Saturating output counter: counts en_i pulses up to len_i.
// Ports: clear_i (sync zero), en_i (count), len_i (limit), cnt_o (value),
// term_o (combinational: cnt + en this cycle has reached len_i).
module multi_dataflow_mul_mdc_engine_cnt
    import multi_dataflow_mul_mdc_package::*;
#(
    parameter int unsigned CNT_W = ENGINE_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   len_ext;

    // One extra bit so len = 2^CNT_W-1 cannot wrap the compare.
    assign len_ext = {1'b0, len_i};
    assign sum     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, en_i};
    assign term_o  = (sum >= len_ext);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && ({1'b0, cnt_q} < len_ext)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/multi_dataflow_mul_mdc_engine_fsm.sv
// Engine-side controller: takes a job, launches streamers, pulses kernel
// start, counts adapter done flags and reports completion.
// Ports: clk_i/rst_ni, clear_i, job_start_i/job_len_i, streamer_ready_i,
// streamer_req_o, kernel_start_o, flags_done_i/ready_i/idle_i, busy_o,
// job_done_o, out_cnt_o; timeout_o only with
// MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN defined (watchdog).
module multi_dataflow_mul_mdc_engine_fsm
    import multi_dataflow_mul_mdc_package::*;
#(
    parameter int unsigned CNT_W          = ENGINE_CNT_W,
    parameter bit          START_ON_READY = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             job_start_i,
    input  logic [CNT_W-1:0] job_len_i,
    input  logic             streamer_ready_i,
    output logic             streamer_req_o,
    output logic             kernel_start_o,
    input  logic             flags_done_i,
    input  logic             flags_ready_i,
    input  logic             flags_idle_i,
`ifdef MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN
    output logic             timeout_o,
`endif
    output logic             busy_o,
    output logic             job_done_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    engine_state_mul_mdc_t state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic sreq_q, sreq_d;
    logic kstart_q, kstart_d;
    logic done_q, done_d;
    logic busy_q, busy_d;
    logic cnt_clr, cnt_en, cnt_term;

`ifdef MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wdg_q, wdg_d;
    logic tmo_q, tmo_d;
    logic wdg_act, wdg_exp;

    assign wdg_act = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
    assign wdg_exp = wdg_act && !flags_done_i
                   && (wdg_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    multi_dataflow_mul_mdc_engine_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cnt_clr),
        .en_i    (cnt_en),
        .len_i   (len_q),
        .cnt_o   (out_cnt_o),
        .term_o  (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sreq_d   = 1'b0;
        kstart_d = 1'b0;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
`ifdef MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN
        tmo_d    = tmo_q;
        wdg_d    = wdg_q;
`endif
        if (clear_i) begin
            state_d = ST_IDLE;
            len_d   = '0;
            cnt_clr = 1'b1;
`ifdef MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN
            tmo_d   = 1'b0;
            wdg_d   = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (job_start_i) begin
                        len_d   = job_len_i;
                        cnt_clr = 1'b1;
                        state_d = (job_len_i != '0) ? ST_STARTING : ST_DONE;
                    end
                end
                ST_STARTING: begin
                    if (streamer_ready_i) begin
                        sreq_d   = 1'b1;
                        kstart_d = 1'b1;
                        state_d  = ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    cnt_en = flags_done_i;
                    // The last output suppresses any restart that cycle.
                    if (cnt_term) begin
                        state_d = ST_DRAIN;
                    end else if (START_ON_READY && flags_ready_i) begin
                        kstart_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (flags_idle_i) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN
            if (wdg_exp) begin
                state_d  = ST_DONE;
                kstart_d = 1'b0;
                tmo_d    = 1'b1;
            end
            if (flags_done_i || (state_d != state_q)) begin
                wdg_d = '0;
            end else if (wdg_act) begin
                wdg_d = wdg_q + TW'(1);
            end
`endif
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            sreq_q   <= 1'b0;
            kstart_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            sreq_q   <= sreq_d;
            kstart_q <= kstart_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef MULTI_DATAFLOW_MUL_MDC_ENGINE_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdg_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            wdg_q <= wdg_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`endif

    assign streamer_req_o = sreq_q;
    assign kernel_start_o = kstart_q;
    assign job_done_o     = done_q;
    assign busy_o         = busy_q;

endmodule
